// File: rtl/ysyx_23060061_gpr_file.sv
// ysyx_23060061_gpr_file
//
// General-purpose register file for the pipelined NPC core with an integrated
// write-pending scoreboard. Decode/issue reads operands and claims destination
// registers. Writeback writes results and releases the claims.
//
// Ports:
//   clk          - single clock, all state updates on the rising edge
//   rst_n        - synchronous active-low reset (data, busy bits and sb_err to 0)
//   raddr        - NREAD packed read addresses, port i at [i*AW +: AW]
//   rdata        - NREAD packed read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rbusy        - per read port: addressed register has a pending write
//   wen          - write enable
//   waddr        - write address
//   wdata        - write data
//   claim        - mark claim_addr as pending
//   claim_addr   - register being claimed
//   release_en   - clear pending bit of release_addr
//   release_addr - register being released
//   flush        - clear all pending bits
//   sb_err       - sticky scoreboard protocol error (double claim / stray release)

module ysyx_23060061_gpr_file #(
    parameter int unsigned NREGS      = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NREAD      = 2,
    parameter bit          ZERO_REG   = 1'b1,
    parameter bit          BYPASS     = 1'b1,
    localparam int unsigned AW        = $clog2(NREGS)
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic [NREAD*AW-1:0]         raddr,
    output logic [NREAD*DATA_WIDTH-1:0] rdata,
    output logic [NREAD-1:0]            rbusy,

    input  logic                        wen,
    input  logic [AW-1:0]               waddr,
    input  logic [DATA_WIDTH-1:0]       wdata,

    input  logic                        claim,
    input  logic [AW-1:0]               claim_addr,
    input  logic                        release_en,
    input  logic [AW-1:0]               release_addr,
    input  logic                        flush,

    output logic                        sb_err
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] regs_q [NREGS];
    logic [NREGS-1:0]      busy_q;
    logic [NREGS-1:0]      busy_d;
    logic                  sb_err_q;
    logic                  sb_err_d;

    // ------------------------------------------------------------------
    // Effective request qualifiers (x0 hardwiring suppresses everything)
    // ------------------------------------------------------------------
    logic wr_eff;
    logic claim_eff;
    logic rel_eff;
    logic same_cr;     // claim and release target the same register
    logic claim_dup;   // claim of a register that is already pending
    logic rel_stray;   // release of a register that is not pending

    always_comb begin
        wr_eff    = wen        && !(ZERO_REG && (waddr        == '0));
        claim_eff = claim      && !(ZERO_REG && (claim_addr   == '0));
        rel_eff   = release_en && !(ZERO_REG && (release_addr == '0));
        same_cr   = claim_eff && rel_eff && (claim_addr == release_addr);

        // A same-cycle release of the claimed register makes the re-claim legal
        // (the old producer retires as the new one issues), and vice versa.
        claim_dup = claim_eff && busy_q[claim_addr]    && !same_cr;
        rel_stray = rel_eff   && !busy_q[release_addr] && !same_cr;
    end

    // ------------------------------------------------------------------
    // Busy-bit next state: flush > claim > release > hold
    // ------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < int'(NREGS); r++) begin
            if (flush) begin
                busy_d[r] = 1'b0;
            end else if (claim_eff && (claim_addr == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if (rel_eff && (release_addr == AW'(r))) begin
                busy_d[r] = 1'b0;
            end
        end
    end

    // Sticky error; a flush squashes the whole cycle's scoreboard traffic so
    // nothing it carries is counted as a protocol violation.
    always_comb begin
        sb_err_d = sb_err_q;
        if (!flush && (claim_dup || rel_stray)) begin
            sb_err_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < int'(NREGS); r++) begin
                regs_q[r] <= '0;
            end
            busy_q   <= '0;
            sb_err_q <= 1'b0;
        end else begin
            // Flush does not block the data write.
            if (wr_eff) begin
                regs_q[waddr] <= wdata;
            end
            busy_q   <= busy_d;
            sb_err_q <= sb_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Combinational read ports
    // ------------------------------------------------------------------
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int p = 0; p < int'(NREAD); p++) begin
            logic [AW-1:0] ra;
            ra = raddr[p*AW +: AW];
            if (ZERO_REG && (ra == '0)) begin
                rdata[p*DATA_WIDTH +: DATA_WIDTH] = '0;
                rbusy[p]                          = 1'b0;
            end else begin
                if (BYPASS && wr_eff && (waddr == ra)) begin
                    rdata[p*DATA_WIDTH +: DATA_WIDTH] = wdata;
                end else begin
                    rdata[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[ra];
                end
                // Busy is never bypassed: it is the registered state only.
                rbusy[p] = busy_q[ra];
            end
        end
    end

    assign sb_err = sb_err_q;

endmodule

// File: doc/ysyx_23060061_gpr_file.md
# ysyx_23060061_gpr_file

Parametrised general-purpose register file with an integrated write-pending scoreboard for the pipelined NPC core. It provides NREAD combinational read ports and one synchronous write port. Optional x0 hardwiring and write-to-read bypass are included. Per-register busy bits let decode detect RAW hazards against in-flight instructions. It sits between decode/issue (reads, claims) and writeback (writes, releases).

## Interface
- NREGS, 32, number of architectural registers (power of two, ≥2; 16 for RV32E)
- DATA_WIDTH, 32, register width in bits
- NREAD, 2, number of read ports (≥1)
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes, is never busy
- BYPASS, 1, 1: a read of the register being written this cycle returns wdata
- AW (localparam), $clog2(NREGS), address width
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- raddr  in  NREAD*AW  read addresses; port i uses bits [i*AW +: AW]
- rdata  out  NREAD*DATA_WIDTH  read data; port i uses bits [i*DATA_WIDTH +: DATA_WIDTH]
- rbusy  out  NREAD  port i address currently has a pending write
- wen  in  1  write enable
- waddr  in  AW  write address
- wdata  in  DATA_WIDTH  write data
- claim  in  1  issue marks register claim_addr as pending
- claim_addr  in  AW  register being claimed
- release_en  in  1  writeback clears pending bit of release_addr (independent of wen)
- release_addr  in  AW  register being released
- flush  in  1  clear all pending bits (pipeline squash)
- sb_err  out  1  sticky: claim of an already-busy register, or release of a non-busy one

## Operation
- Storage: NREGS x DATA_WIDTH array plus NREGS busy bits plus sb_err flag.
- Reset (rst_n=0 at edge): all registers ← 0, all busy ← 0, sb_err ← 0. Writes, claims and releases in the same cycle are ignored.
- Write: at the edge, if wen and not (ZERO_REG and waddr==0), reg[waddr] ← wdata.
- Read port i is combinational:
  - If ZERO_REG and raddr_i==0: rdata_i = 0.
  - Else if BYPASS and wen and waddr==raddr_i (and the write is not suppressed): rdata_i = wdata.
  - Else rdata_i = reg[raddr_i].
- rbusy_i = busy[raddr_i]. Not bypassed: it reflects the registered busy state only. It is 0 for address 0 when ZERO_REG=1.
- Busy next-state per register r, in priority order:
  1. flush: busy ← 0.
  2. claim hits r: busy ← 1. A same-cycle release of r loses, because the new instruction owns r.
  3. release hits r: busy ← 0.
  4. Otherwise: hold.
- With ZERO_REG=1, claims and releases of address 0 are ignored and do not set sb_err.
- sb_err is set, when flush=0, in either case:
  - Claim of r while busy[r]=1 and no same-cycle release of r.
  - Release of r while busy[r]=0 and no same-cycle claim of r.
- sb_err stays set until reset; flush does not clear it.
- Flush does not block a same-cycle write: the data write still occurs.

## Timing
- Read latency 0 (combinational from raddr, and from wen/waddr/wdata when BYPASS=1).
- Write visible through the array on the cycle after the edge. Visible the same cycle only via bypass.
- Claim/release/flush take effect at the edge. rbusy reflects them the next cycle.
- Every read port operates independently: any number of ports may read the same address.
- Simultaneous claim and release of different registers both apply.

## Test plan
- Reset then read: after rst_n low for one cycle, every port reads 0 on addresses 0..NREGS-1, rbusy=0, sb_err=0.
- Write/readback and bypass: write 0xDEADBEEF to x5. In the same cycle raddr0=5 gives 0xDEADBEEF (BYPASS=1). Next cycle both ports on x5 give 0xDEADBEEF. Write 0x1234 to x0, then read x0 = 0.
- Scoreboard: claim x7 → next cycle rbusy for x7 is 1. Release x7 together with a write of 0x55 → next cycle rbusy=0 and data=0x55. Claim x0 → rbusy stays 0.
- Same-cycle claim and release of x9 while busy → x9 stays busy, sb_err stays 0. Claim x9 again without a release → sb_err=1 and stays 1 after a flush.
- Flush: claim x3, x4, x5 on successive cycles, then flush with claim x6 in the same cycle → all busy bits 0, including x6.
- Mid-operation reset: registers hold nonzero data and busy bits are set. Assert rst_n=0 with wen=1 and claim=1 → next cycle all data 0, busy 0, sb_err 0.
